// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and defaults for the I/D memory arbiter.
//   arb_state_t  - arbiter FSM state encoding
//   owner_t      - encoding of the registered owner output (OWN_NONE/OWN_I/OWN_D)
//   owner_of()   - maps an FSM state to its owner encoding
package mem_arbiter_pkg;

  localparam int MAX_HOLD_DEF = 16;
  localparam int AW_DEF       = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } arb_state_t;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'b00;
  localparam owner_t OWN_I    = 2'b01;
  localparam owner_t OWN_D    = 2'b10;

  function automatic owner_t owner_of(arb_state_t st);
    case (st)
      ST_GRANT_I: return OWN_I;
      ST_GRANT_D: return OWN_D;
      default:    return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the two cache controllers, the arbiter
// and the shared four-bank memory.
//   i_* / d_*      - instruction / data side request, strobes, address, write data, grant
//   mem_*          - shared memory command (mem_stall is the memory busy input)
//   owner, err     - current owner encoding and sticky fault flag
// Modports: slave = arbiter view, master = requester/memory-model view.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF
) ();

  logic          i_req;
  logic          i_rd;
  logic          i_wr;
  logic [AW-1:0] i_addr;
  logic [AW-1:0] i_data_in;
  logic          i_gnt;

  logic          d_req;
  logic          d_rd;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [AW-1:0] d_data_in;
  logic          d_gnt;

  logic          mem_stall;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] mem_data_in;

  owner_t        owner;
  logic          err;

  modport slave (
    input  i_req, i_rd, i_wr, i_addr, i_data_in,
    input  d_req, d_rd, d_wr, d_addr, d_data_in,
    input  mem_stall,
    output i_gnt, d_gnt,
    output mem_rd, mem_wr, mem_addr, mem_data_in,
    output owner, err
  );

  modport master (
    output i_req, i_rd, i_wr, i_addr, i_data_in,
    output d_req, d_rd, d_wr, d_addr, d_data_in,
    output mem_stall,
    input  i_gnt, d_gnt,
    input  mem_rd, mem_wr, mem_addr, mem_data_in,
    input  owner, err
  );

endinterface

// File: rtl/mem_arb_holdcnt.sv
// mem_arb_holdcnt: counts non-stalled cycles of the current grant.
//   clk, rst_n - clock, async active-low reset
//   clr        - hold the count at zero (asserted while no grant is active)
//   en         - count this cycle (grant active and memory not stalled)
//   tc         - this counted cycle brings the count to MAX_HOLD
module mem_arb_holdcnt
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            CW   = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Flags the cycle whose increment reaches MAX_HOLD, so the FSM can leave
  // the grant on the same edge the count lands on the limit.
  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (I-cache / D-cache) arbiter for a shared memory.
//   clk, rst_n - clock, async active-low reset
//   bus        - mem_arbiter_if.slave: requests/strobes in, grants, memory
//                command, owner and sticky err out
// Parameters: MAX_HOLD (non-stalled cycles a grant may be held), AW (width).
// Build option: MEM_ARB_DPRIO_EN - ties always go to the data side; otherwise
// ties alternate using a last-owner flop (I wins the first tie after reset).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no owner; memory command forced to zero; arbitration point
// ST_GRANT_I | instruction side drives the memory command
// ST_GRANT_D | data side drives the memory command
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int AW       = AW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [AW-1:0] ZERO = '0;

  arb_state_t state;
  arb_state_t state_nxt;
  logic       hold_tc;
  logic       revoke_i;
  logic       revoke_d;
  logic       lock_i;
  logic       lock_d;
  logic       req_i;
  logic       req_d;
  logic       tie_to_d;
  logic       dual_strobe;

  // A side whose grant was revoked is ignored until it drops its request.
  assign req_i = bus.i_req && !lock_i;
  assign req_d = bus.d_req && !lock_d;

`ifdef MEM_ARB_DPRIO_EN
  assign tie_to_d = 1'b1;
`else
  logic last_d;

  assign tie_to_d = !last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b1;
    end else if (state_nxt == ST_GRANT_I || revoke_i) begin
      last_d <= 1'b0;
    end else if (state_nxt == ST_GRANT_D || revoke_d) begin
      last_d <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    revoke_i  = 1'b0;
    revoke_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_i && req_d) begin
          state_nxt = tie_to_d ? ST_GRANT_D : ST_GRANT_I;
        end else if (req_i) begin
          state_nxt = ST_GRANT_I;
        end else if (req_d) begin
          state_nxt = ST_GRANT_D;
        end
      end
      // A release in the same cycle the limit is reached is a normal release.
      ST_GRANT_I: begin
        if (!bus.i_req) begin
          state_nxt = ST_IDLE;
        end else if (hold_tc) begin
          state_nxt = ST_IDLE;
          revoke_i  = 1'b1;
        end
      end
      ST_GRANT_D: begin
        if (!bus.d_req) begin
          state_nxt = ST_IDLE;
        end else if (hold_tc) begin
          state_nxt = ST_IDLE;
          revoke_d  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grants and owner are registered copies of the next state, so they match
  // the state register exactly and clear with it asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bus.i_gnt <= 1'b0;
      bus.d_gnt <= 1'b0;
      bus.owner <= OWN_NONE;
    end else begin
      state     <= state_nxt;
      bus.i_gnt <= (state_nxt == ST_GRANT_I);
      bus.d_gnt <= (state_nxt == ST_GRANT_D);
      bus.owner <= owner_of(state_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_i <= 1'b0;
      lock_d <= 1'b0;
    end else begin
      if (revoke_i) begin
        lock_i <= 1'b1;
      end else if (!bus.i_req) begin
        lock_i <= 1'b0;
      end
      if (revoke_d) begin
        lock_d <= 1'b1;
      end else if (!bus.d_req) begin
        lock_d <= 1'b0;
      end
    end
  end

  assign dual_strobe = (state == ST_GRANT_I && bus.i_rd && bus.i_wr) ||
                       (state == ST_GRANT_D && bus.d_rd && bus.d_wr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.err <= 1'b0;
    end else if (revoke_i || revoke_d || dual_strobe) begin
      bus.err <= 1'b1;
    end
  end

  // Memory command is a combinational pass-through of the owning side;
  // a simultaneous read+write is suppressed rather than forwarded.
  always_comb begin
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = ZERO;
    bus.mem_data_in = ZERO;
    case (state)
      ST_GRANT_I: begin
        bus.mem_rd      = bus.i_rd && !bus.i_wr;
        bus.mem_wr      = bus.i_wr && !bus.i_rd;
        bus.mem_addr    = bus.i_addr;
        bus.mem_data_in = bus.i_data_in;
      end
      ST_GRANT_D: begin
        bus.mem_rd      = bus.d_rd && !bus.d_wr;
        bus.mem_wr      = bus.d_wr && !bus.d_rd;
        bus.mem_addr    = bus.d_addr;
        bus.mem_data_in = bus.d_data_in;
      end
      default: ;
    endcase
  end

  mem_arb_holdcnt #(
    .MAX_HOLD (MAX_HOLD)
  ) u_holdcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_IDLE),
    .en    (state != ST_IDLE && !bus.mem_stall),
    .tc    (hold_tc)
  );

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: maximum non-stalled cycles one grant may be held.
REQ-002 SHALL have parameter AW, default 16: address and data width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports i_req, i_rd, i_wr, input, 1 each: instruction-cache controller request, read strobe and write strobe.
REQ-006 SHALL have ports i_addr and i_data_in, input, AW each: instruction-side address and write data.
REQ-007 SHALL have ports d_req, d_rd, d_wr, input, 1 each, and d_addr and d_data_in, input, AW each: the data-cache controller equivalents.
REQ-008 SHALL have ports i_gnt and d_gnt, output, 1 each: registered grants.
REQ-009 SHALL have port mem_stall, input, 1: four-bank memory busy.
REQ-010 SHALL have ports mem_rd and mem_wr, output, 1 each, and mem_addr and mem_data_in, output, AW each: the shared memory command.
REQ-011 SHALL have port owner, output, 2: 00 none, 01 I, 10 D.
REQ-012 SHALL have port err, output, 1: sticky fault flag.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT_I and GRANT_D.
REQ-014 IDLE: if only one req is high, the next state SHALL be that side's GRANT_x; if both are high, tie-break per REQ-016; otherwise stay in IDLE.
REQ-015 GRANT_x: the state SHALL be held while x_req is high; when x_req falls, go to IDLE, which gives one mandatory dead cycle between owners.
REQ-016 Tie-break SHALL be round-robin via a last_owner flop; reset value D, so I wins the first tie.
REQ-017 x_gnt SHALL be high exactly in GRANT_x.
REQ-018 Grant latency SHALL be 1 cycle from request in IDLE to x_gnt.
REQ-019 In GRANT_x, mem_rd, mem_wr, mem_addr and mem_data_in SHALL combinationally equal the x-side inputs.
REQ-020 In IDLE, mem_rd and mem_wr SHALL be 0, and mem_addr and mem_data_in SHALL be 0.
REQ-021 Non-granted requester strobes SHALL be ignored.
REQ-022 In GRANT_x with x_rd and x_wr both high, mem_rd and mem_wr SHALL be forced 0 and err SHALL be set.
REQ-023 The hold counter (width clog2(MAX_HOLD)+1) SHALL clear on entry to GRANT_x and increment on each GRANT cycle with mem_stall low.
REQ-024 While mem_stall is high, the hold counter SHALL be frozen.
REQ-025 When the hold counter reaches MAX_HOLD while x_req is still high: the grant SHALL be revoked (next state IDLE), err SHALL be set, and last_owner SHALL be set to x.
REQ-026 A side whose grant was revoked per REQ-025 SHALL NOT be granted again until its req has been low at least one cycle.
REQ-027 When req drops and the counter reaches MAX_HOLD in the same cycle, the transition SHALL be a normal release with no err.
REQ-028 mem_stall SHALL NOT affect grant transitions; only owner timing is tracked.
REQ-029 owner SHALL be a registered encoding of the state.

Reset
REQ-030 On rst_n low, asynchronously: state IDLE, last_owner D, hold counter 0, err 0, revoke-lock flags 0.
REQ-031 On rst_n low, i_gnt, d_gnt, mem_rd and mem_wr SHALL be 0 and owner SHALL be 00.
REQ-032 Reset asserted mid-grant SHALL drop the grant immediately; an in-flight burst is abandoned with no recovery.

Configuration
REQ-033 With MEM_ARB_DPRIO_EN defined, ties in IDLE SHALL always go to D, and last_owner SHALL be unused.
REQ-034 Without MEM_ARB_DPRIO_EN, ties SHALL be round-robin per REQ-016.

Structure
REQ-035 The shared package SHALL hold the state encoding, the owner encoding (OWN_NONE, OWN_I, OWN_D) and the MAX_HOLD default.
REQ-036 One sub-module SHALL be natural: mem_arb_holdcnt, the hold counter with freeze on stall and a terminal flag.
REQ-037 Grant and state registers SHALL be flops with asynchronous clear.

Verification
REQ-038 Scenario: i_req alone rises at cycle 0 -> i_gnt=1 at cycle 1; mem_addr follows i_addr=0x1234 with i_rd=1 -> mem_rd=1, mem_addr=0x1234.
REQ-039 Scenario: i_req and d_req rise together after reset -> I granted first; I releases -> 1 dead cycle -> D granted; next tie -> I.
REQ-040 Scenario: same tie with MEM_ARB_DPRIO_EN defined -> D granted on every tie.
REQ-041 Scenario: D holds req for 20 non-stall cycles, MAX_HOLD=16 -> d_gnt drops after 16 counted cycles, err=1, I granted if requesting, D not regranted until d_req toggles low.
REQ-042 Scenario: mem_stall high for 10 cycles during a grant -> counter frozen, no revoke before 16 non-stall cycles.
REQ-043 Scenario: rst_n pulled low while d_gnt=1 and d_wr=1 -> d_gnt, mem_wr, owner and err go 0 without waiting for a clock edge.
